sel_merge_2_sync: RTL and testbench

Clocked conditional merge (select-join) for the drive/free handshake fabric. It is the receiving-end counterpart of the two-way conditional split. Each of two upstream channels delivers a drive pulse. Once every channel selected by valid0/valid1 has driven, the block issues one drive pulse downstream. When the downstream free returns, it pulses free back to exactly the selected upstream channels. Programmable cycle delays stand in for the async delay elements, so the block can be used inside synchronous FPGA control paths.

---
 rtl/sel_merge_2_sync.sv | 182 ++++++++++++++++++
 tb/tb_sel_merge_2_sync.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/sel_merge_2_sync.sv
// Clocked two-way conditional merge for the drive/free handshake fabric.
// Collects the selected upstream drives, fires one downstream drive, and
// returns free only to the selected channels after downstream frees.
//
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   valid0, valid1     : channel participation, sampled in IDLE
//   i_drive0/1         : upstream drive pulses
//   i_freeNext         : downstream free pulse
//   o_driveNext        : one-cycle downstream drive pulse
//   o_free0/1          : one-cycle upstream free pulses
//   o_busy             : transaction in progress
//   o_err              : one-cycle protocol-violation flag
module sel_merge_2_sync #(
  parameter int unsigned FIRE_DLY = 2,
  parameter int unsigned FREE_DLY = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic valid0,
  input  logic valid1,
  input  logic i_drive0,
  input  logic i_drive1,
  input  logic i_freeNext,
  output logic o_driveNext,
  output logic o_free0,
  output logic o_free1,
  output logic o_busy,
  output logic o_err
);

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    FIRE_WAIT,
    WAIT_FREE,
    FREE_WAIT,
    RELEASE
  } state_e;

  localparam logic [3:0] FIRE_LD = 4'(FIRE_DLY);
  localparam logic [3:0] FREE_LD = 4'(FREE_DLY);

  state_e     state_q, state_d;
  logic [1:0] col_q, col_d;
  logic [1:0] sel_q, sel_d;
  logic [3:0] cnt_q, cnt_d;
  logic       drv_q, free0_q, free1_q;
  logic       busy_q, err_q;

  logic [1:0] drv, vld, acc;
  logic       go_fire, go_free;
  logic       fire, rel, err;

  assign drv = {i_drive1, i_drive0};
  assign vld = {valid1, valid0};

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    acc     = 2'b00;
    go_fire = 1'b0;
    go_free = 1'b0;
    fire    = 1'b0;
    rel     = 1'b0;
    err     = 1'b0;

    unique case (state_q)
      IDLE: begin
        acc = drv & vld;
        err = (|(drv & ~vld)) | i_freeNext;
        if (|acc) begin
          sel_d = vld;
          col_d = acc;
          if (acc == vld) begin
            go_fire = 1'b1;
          end else begin
            state_d = COLLECT;
          end
        end
      end
      COLLECT: begin
        // only selected, not-yet-collected channels count
        acc   = drv & sel_q & ~col_q;
        err   = (|(drv & ~acc)) | i_freeNext;
        col_d = col_q | acc;
        if ((col_q | acc) == sel_q) begin
          go_fire = 1'b1;
        end
      end
      FIRE_WAIT: begin
        err = (|drv) | i_freeNext;
        if (cnt_q == 4'd1) begin
          fire    = 1'b1;
          cnt_d   = 4'd0;
          state_d = WAIT_FREE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      WAIT_FREE: begin
        err = |drv;
        if (i_freeNext) begin
          go_free = 1'b1;
        end
      end
      FREE_WAIT: begin
        err = (|drv) | i_freeNext;
        if (cnt_q == 4'd1) begin
          rel     = 1'b1;
          cnt_d   = 4'd0;
          state_d = RELEASE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RELEASE: begin
        err     = (|drv) | i_freeNext;
        col_d   = 2'b00;
        sel_d   = 2'b00;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // zero delay skips the wait state and pulses on the entry edge
    if (go_fire) begin
      if (FIRE_LD == 4'd0) begin
        fire    = 1'b1;
        state_d = WAIT_FREE;
      end else begin
        cnt_d   = FIRE_LD;
        state_d = FIRE_WAIT;
      end
    end

    if (go_free) begin
      if (FREE_LD == 4'd0) begin
        rel     = 1'b1;
        state_d = RELEASE;
      end else begin
        cnt_d   = FREE_LD;
        state_d = FREE_WAIT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      col_q   <= 2'b00;
      sel_q   <= 2'b00;
      cnt_q   <= 4'd0;
      drv_q   <= 1'b0;
      free0_q <= 1'b0;
      free1_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      drv_q   <= fire;
      free0_q <= rel & sel_q[0];
      free1_q <= rel & sel_q[1];
      busy_q  <= (state_d != IDLE);
      err_q   <= err;
    end
  end

  assign o_driveNext = drv_q;
  assign o_free0     = free0_q;
  assign o_free1     = free1_q;
  assign o_busy      = busy_q;
  assign o_err       = err_q;

endmodule

// File: tb/tb_sel_merge_2_sync.sv
// Directed bench for sel_merge_2_sync.
// Output vector order: {driveNext, free0, free1, busy, err}.
module tb_sel_merge_2_sync;

  logic clk = 1'b0;
  logic rst, valid0, valid1, d0, d1, fn;
  logic dn, f0, f1, busy, err;
  logic dn_z, f0_z, f1_z, busy_z, err_z;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sel_merge_2_sync #(.FIRE_DLY(2), .FREE_DLY(2)) dut (
    .clk(clk), .rst(rst),
    .valid0(valid0), .valid1(valid1),
    .i_drive0(d0), .i_drive1(d1),
    .i_freeNext(fn),
    .o_driveNext(dn), .o_free0(f0), .o_free1(f1),
    .o_busy(busy), .o_err(err)
  );

  sel_merge_2_sync #(.FIRE_DLY(0), .FREE_DLY(0)) dut0 (
    .clk(clk), .rst(rst),
    .valid0(valid0), .valid1(valid1),
    .i_drive0(d0), .i_drive1(d1),
    .i_freeNext(fn),
    .o_driveNext(dn_z), .o_free0(f0_z), .o_free1(f1_z),
    .o_busy(busy_z), .o_err(err_z)
  );

  task automatic apply_reset();
    rst = 1'b1;
    valid0 = 1'b0; valid1 = 1'b0;
    d0 = 1'b0; d1 = 1'b0; fn = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [4:0] got, got_z;
    apply_reset();
    for (int c = 1; c <= 3; c++) begin
      got   = {dn, f0, f1, busy, err};
      got_z = {dn_z, f0_z, f1_z, busy_z, err_z};
      checks++;
      if (got !== 5'b0) begin
        errors++;
        $display("FAIL reset cyc=%0d got=%b exp=00000", c, got);
      end
      checks++;
      if (got_z !== 5'b0) begin
        errors++;
        $display("FAIL reset_z cyc=%0d got=%b exp=00000", c, got_z);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_basic();
    logic [4:0] got, exp;
    apply_reset();
    for (int c = 1; c <= 26; c++) begin
      got = {dn, f0, f1, busy, err};
      exp = {c == 16, c == 23, c == 23, c >= 11 && c <= 23, 1'b0};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL basic cyc=%0d got=%b exp=%b", c, got, exp);
      end
      valid0 = 1'b1; valid1 = 1'b1;
      d0 = (c == 10); d1 = (c == 13); fn = (c == 20);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_single_sel();
    logic [4:0] got, exp;
    apply_reset();
    for (int c = 1; c <= 17; c++) begin
      got = {dn, f0, f1, busy, err};
      exp = {c == 8, c == 15, 1'b0, c >= 6 && c <= 15, c == 7};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL single_sel cyc=%0d got=%b exp=%b", c, got, exp);
      end
      valid0 = 1'b1; valid1 = 1'b0;
      d0 = (c == 5); d1 = (c == 6); fn = (c == 12);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_simultaneous();
    logic [4:0] got, exp, got_z, exp_z;
    apply_reset();
    for (int c = 1; c <= 15; c++) begin
      got   = {dn, f0, f1, busy, err};
      exp   = {c == 8, c == 13, c == 13, c >= 6 && c <= 13, 1'b0};
      got_z = {dn_z, f0_z, f1_z, busy_z, err_z};
      exp_z = {c == 6, c == 11, c == 11, c >= 6 && c <= 11, 1'b0};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL simul cyc=%0d got=%b exp=%b", c, got, exp);
      end
      checks++;
      if (got_z !== exp_z) begin
        errors++;
        $display("FAIL simul_dly0 cyc=%0d got=%b exp=%b", c, got_z, exp_z);
      end
      valid0 = 1'b1; valid1 = 1'b1;
      d0 = (c == 5); d1 = (c == 5); fn = (c == 10);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_violations();
    logic [4:0] got, exp;
    logic       e;
    apply_reset();
    for (int c = 1; c <= 19; c++) begin
      got = {dn, f0, f1, busy, err};
      e   = (c == 3) || (c == 4) || (c == 8);
      exp = {c == 12, c == 17, c == 17, c >= 6 && c <= 17, e};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL violations cyc=%0d got=%b exp=%b", c, got, exp);
      end
      valid0 = (c != 3); valid1 = (c != 3);
      d0 = (c == 3) || (c == 5) || (c == 7);
      d1 = (c == 9);
      fn = (c == 2) || (c == 14);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mid_reset();
    logic [4:0] got, exp;
    logic       b;
    apply_reset();
    for (int c = 1; c <= 19; c++) begin
      got = {dn, f0, f1, busy, err};
      b   = (c >= 4 && c <= 9) || (c >= 15);
      exp = {c == 6 || c == 17, 1'b0, 1'b0, b, c == 12};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL mid_reset cyc=%0d got=%b exp=%b", c, got, exp);
      end
      rst = (c == 9);
      valid0 = 1'b1; valid1 = 1'b0;
      d0 = (c == 3) || (c == 14); d1 = 1'b0;
      fn = (c == 11);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] got, exp;
    logic       b;
    apply_reset();
    for (int c = 1; c <= 21; c++) begin
      got = {dn, f0, f1, busy, err};
      b   = (c >= 3 && c <= 10) || (c >= 12 && c <= 19);
      exp = {c == 5 || c == 14, c == 10 || c == 19, 1'b0, b, c == 11};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL back_to_back cyc=%0d got=%b exp=%b", c, got, exp);
      end
      valid0 = 1'b1; valid1 = 1'b0;
      d0 = (c == 2) || (c == 10) || (c == 11); d1 = 1'b0;
      fn = (c == 7) || (c == 16);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_single_sel();
    test_simultaneous();
    test_violations();
    test_mid_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
